// File: rtl/uart_tx_word.sv
// uart_tx_word: serializes one W_BUS-bit result bus as N_WORDS back-to-back
// UART frames (start bit, LSB-first data, high padding up to PACKET_SIZE).
module uart_tx_word #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE      = 13,
  parameter int W_BUS            = 96
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W_BUS-1:0] s_data,
  output logic             tx,
  output logic             busy
);
  localparam int N_WORDS = W_BUS / BITS_PER_WORD;
  localparam int PULSE_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BIT_W   = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
  localparam int WORD_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int PAD     = PACKET_SIZE - BITS_PER_WORD - 1;

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(PACKET_SIZE - 1);
  localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(N_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e             state_q, state_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]  word_cnt_q, word_cnt_d;
  logic [W_BUS-1:0]   shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic [PACKET_SIZE-1:0] frame;

  // Next-state: accept in IDLE, then walk pulse/bit/word counters in SEND.
  // The current word always sits in the low bits of the shift register.
  // tx is registered from the *next* counter values so the line changes on
  // the same edge the counters do (start bit appears right after accept).
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    shreg_d     = shreg_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d     = SEND;
          shreg_d     = s_data;
          pulse_cnt_d = '0;
          bit_cnt_d   = '0;
          word_cnt_d  = '0;
        end
      end
      SEND: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          pulse_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (word_cnt_q == WORD_LAST) begin
              state_d    = IDLE;
              word_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
              shreg_d    = shreg_q >> BITS_PER_WORD;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    frame = {{PAD{1'b1}}, shreg_d[BITS_PER_WORD-1:0], 1'b0};
    tx_d  = (state_d == SEND) ? frame[bit_cnt_d] : 1'b1;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      shreg_q     <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign busy    = (state_q == SEND);
  assign tx      = tx_q;
endmodule

// File: doc/uart_tx_word.md
Name: uart_tx_word

Overview:
- Parallel-to-serial UART transmitter for the result path of the MVM UART system.
- Accepts one W_BUS-bit result bus, e.g. R=3 outputs of W_Y_OUT=32 bits, through a valid/ready handshake.
- Serializes the bus as N_WORDS consecutive UART frames on `tx`, word 0 first.
- Frame format: 1 start bit, BITS_PER_WORD data bits LSB-first, then high stop/padding bits up to PACKET_SIZE bits.

Parameters:
- CLOCKS_PER_PULSE, 4: clock cycles per UART bit; must be >= 2.
- BITS_PER_WORD, 8: data bits per frame.
- PACKET_SIZE, 13: total bits per frame (start + data + stop/padding); must be >= BITS_PER_WORD+2.
- W_BUS, 96: width of the parallel input bus; must satisfy W_BUS % BITS_PER_WORD == 0.
- N_WORDS, W_BUS/BITS_PER_WORD: derived localparam; frames per bus, 12 at the defaults.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rstn, input, 1: reset, synchronous, active-low.
- s_valid, input, 1: the input bus holds a result to send.
- s_ready, output, 1: the block can accept a new bus.
- s_data, input, W_BUS: result bus; word i = s_data[i*BITS_PER_WORD +: BITS_PER_WORD].
- tx, output, 1: serial line; idles high.
- busy, output, 1: high while any frame of the current bus is in flight.

Behaviour:
- Reset (rstn low at a clk edge) forces tx=1, s_ready=1, busy=0, state=IDLE, and clears all counters. This applies mid-frame too: the frame is abandoned, the line returns high on that edge, and there is no partial resume.
- The FSM has two states, IDLE and SEND. s_ready = (state==IDLE); busy = (state==SEND).
- IDLE:
  - tx=1.
  - On s_valid && s_ready at an edge: capture s_data into the shift buffer, word_cnt=0, bit_cnt=0, pulse_cnt=0, go to SEND.
  - tx drives the start bit (0) from the cycle after the accept edge.
- SEND:
  - tx is registered from frame bit bit_cnt of the current word:
    - bit 0 = 0 (start);
    - bits 1..BITS_PER_WORD = data LSB-first;
    - bits BITS_PER_WORD+1 .. PACKET_SIZE-1 = 1.
  - Each bit is held exactly CLOCKS_PER_PULSE cycles. pulse_cnt counts 0..CLOCKS_PER_PULSE-1 and wraps; on the wrap, bit_cnt increments.
  - When bit_cnt wraps from PACKET_SIZE-1, word_cnt increments. The next frame's start bit follows the last padding bit immediately, with no idle gap.
  - After the last padding bit of word N_WORDS-1 completes, go to IDLE: s_ready=1 and tx=1 on that cycle.
- Latency:
  - Accept edge to first start-bit falling edge: 1 cycle.
  - Total SEND duration: N_WORDS*PACKET_SIZE*CLOCKS_PER_PULSE cycles (624 at the defaults).
- s_valid during SEND is ignored and s_data is not sampled. The captured data is stable for the whole transfer even if s_data changes.
- Back-to-back: if s_valid is held high, the next bus is accepted on the first IDLE cycle. Consecutive buses are therefore separated by exactly 1 high idle cycle on tx.
- Counter widths: $clog2 of each range, minimum 1 bit. No arithmetic beyond the counters; no overflow is possible within the parameter constraints.
- A receiver sampling mid-bit, i.e. CLOCKS_PER_PULSE/2 cycles after the falling edge and then every CLOCKS_PER_PULSE cycles, must read correct data, and must read 1 for all PACKET_SIZE-BITS_PER_WORD-1 trailing bits.

Test Plan:
- Reset idle: hold rstn=0 for 2 cycles, then release with s_valid=0 for 50 cycles. Required: tx=1, s_ready=1, busy=0 throughout.
- Single bus: s_data words {0x55, 0xA3, 0x00, 0xFF, 0x01, ...}, pulse s_valid for 1 cycle.
  - tx falls exactly 1 cycle after the accept edge.
  - The mid-bit sampling monitor recovers all 12 bytes in order, with 4 high trailing bits per frame.
  - s_ready returns high exactly 624 cycles after the accept edge.
- MVM result: s_data = {32'd241, 32'd311, 32'd130} (y2,y1,y0). Required: bytes on tx are 0x82,0x00,0x00,0x00,0x37,0x01,0x00,0x00,0xF1,0x00,0x00,0x00.
- Data change during SEND: change s_data and toggle s_valid during transmission. Required: output bytes equal the values captured at accept; no second accept occurs until IDLE.
- Back-to-back: hold s_valid=1 with two different buses. Required: both buses are transmitted intact, with exactly one tx=1 idle cycle between the final padding bit and the next start bit.
- Reset mid-frame: drive rstn=0 during data bit 3 of word 5.
  - tx=1 and s_ready=1 from the reset edge.
  - After release, a new bus transmits correctly from word 0.
